// File: rtl/ex_led_flow_pkg.sv
// Shared encodings for the LED pattern demo: pattern modes, FSM states and
// bounce direction. Imported by the top and by anything decoding its state.
package ex_led_flow_pkg;

    typedef enum logic [1:0] {
        MODE_RL  = 2'b00,   // ring rotate left
        MODE_RR  = 2'b01,   // ring rotate right
        MODE_BNC = 2'b10,   // one-hot bounce between the ends
        MODE_BLK = 2'b11    // all LEDs blink together
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_e;

    typedef enum logic {
        DIR_LEFT  = 1'b0,
        DIR_RIGHT = 1'b1
    } dir_e;

endpackage

// File: rtl/ex_prescaler.sv
// Prescaler: counts sclk cycles while run is high and emits a registered
// one-cycle tick each time the count wraps from DIV_MAX-1 back to 0.
// With run low the count is parked at 0, so the next run phase always
// yields its first tick exactly DIV_MAX cycles later.
module ex_prescaler #(
    parameter int DIV_MAX = 25_000_000,
    parameter int CNT_W   = 25
) (
    input  logic sclk,
    input  logic rst,
    input  logic run,
    output logic tick
);

    localparam logic [CNT_W-1:0] PRESC_LAST = CNT_W'(DIV_MAX - 1);
    localparam logic [CNT_W-1:0] PRESC_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] PRESC_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] presc_r;
    logic             tick_r;

    // Count cycles while running; wrap and pulse tick at the last count.
    always_ff @(posedge sclk) begin
        if (rst) begin
            presc_r <= PRESC_ZERO;
            tick_r  <= 1'b0;
        end else if (!run) begin
            presc_r <= PRESC_ZERO;
            tick_r  <= 1'b0;
        end else if (presc_r == PRESC_LAST) begin
            presc_r <= PRESC_ZERO;
            tick_r  <= 1'b1;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
            tick_r  <= 1'b0;
        end
    end

    assign tick = tick_r;

endmodule

// File: rtl/ex_led_flow.sv
// LED pattern stage: a prescaler tick steps a small IDLE/LOAD/RUN FSM that
// drives ring, bounce or blink patterns onto the board LEDs. Enable is only
// acted on at tick boundaries while running, and the pattern mode is frozen
// at LOAD, so a step is never disturbed by input changes between ticks.
module ex_led_flow
    import ex_led_flow_pkg::*;
#(
    parameter int DIV_MAX = 25_000_000,
    parameter int LED_W   = 4,
    parameter int CNT_W   = 25
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    output logic [LED_W-1:0] led,
    output logic             tick,
    output logic             busy
);

    localparam logic [LED_W-1:0] LED_OFF = {LED_W{1'b0}};
    localparam logic [LED_W-1:0] LED_ALL = {LED_W{1'b1}};

    state_e           state_r, state_s;
    mode_e            mode_r,  mode_s;
    dir_e             dir_r,   dir_s;
    logic [LED_W-1:0] led_r,   led_s;
    logic             busy_r;
    logic             tick_s;
    logic             run_s;

    // Starting pattern for a freshly loaded mode.
    function automatic logic [LED_W-1:0] load_pattern(input mode_e m);
        logic [LED_W-1:0] p;
        p = LED_OFF;
        case (m)
            MODE_RR:  p[LED_W-1] = 1'b1;
            MODE_BLK: p          = LED_ALL;
            default:  p[0]       = 1'b1;
        endcase
        return p;
    endfunction

    // The counter runs whenever a pattern is active or about to start. On the
    // tick that drops back to IDLE it is parked, so a quick re-enable still
    // waits a full period for its first step.
    always_comb begin
        run_s = en;
        if (state_r != ST_IDLE) begin
            run_s = en || !tick_s;
        end else begin
            run_s = en;
        end
    end

    ex_prescaler #(
        .DIV_MAX (DIV_MAX),
        .CNT_W   (CNT_W)
    ) u_prescaler (
        .sclk (sclk),
        .rst  (rst),
        .run  (run_s),
        .tick (tick_s)
    );

    // Next-state, latched mode/direction and next LED pattern.
    always_comb begin
        state_s = state_r;
        mode_s  = mode_r;
        dir_s   = dir_r;
        led_s   = led_r;
        case (state_r)
            ST_IDLE: begin
                if (en) begin
                    state_s = ST_LOAD;
                    mode_s  = mode_e'(mode);
                    dir_s   = DIR_LEFT;
                    led_s   = load_pattern(mode_e'(mode));
                end else begin
                    state_s = ST_IDLE;
                    led_s   = LED_OFF;
                end
            end
            ST_LOAD: begin
                state_s = ST_RUN;
            end
            ST_RUN: begin
                if (tick_s && en) begin
                    case (mode_r)
                        MODE_RL:  led_s = {led_r[LED_W-2:0], led_r[LED_W-1]};
                        MODE_RR:  led_s = {led_r[0], led_r[LED_W-1:1]};
                        MODE_BNC: begin
                            // Turn around at the ends in the same step so the
                            // end LED is never shown twice in a row.
                            if (dir_r == DIR_LEFT) begin
                                if (led_r[LED_W-1]) begin
                                    led_s = {1'b0, led_r[LED_W-1:1]};
                                    dir_s = DIR_RIGHT;
                                end else begin
                                    led_s = {led_r[LED_W-2:0], 1'b0};
                                end
                            end else begin
                                if (led_r[0]) begin
                                    led_s = {led_r[LED_W-2:0], 1'b0};
                                    dir_s = DIR_LEFT;
                                end else begin
                                    led_s = {1'b0, led_r[LED_W-1:1]};
                                end
                            end
                        end
                        MODE_BLK: led_s = ~led_r;
                        default:  led_s = led_r;
                    endcase
                end else if (tick_s) begin
                    state_s = ST_IDLE;
                    dir_s   = DIR_LEFT;
                    led_s   = LED_OFF;
                end else begin
                    state_s = ST_RUN;
                end
            end
            default: begin
                state_s = ST_IDLE;
                dir_s   = DIR_LEFT;
                led_s   = LED_OFF;
            end
        endcase
    end

    // State, pattern and busy registers; busy tracks the state being entered.
    always_ff @(posedge sclk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            mode_r  <= MODE_RL;
            dir_r   <= DIR_LEFT;
            led_r   <= LED_OFF;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            mode_r  <= mode_s;
            dir_r   <= dir_s;
            led_r   <= led_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign led  = led_r;
    assign tick = tick_s;
    assign busy = busy_r;

endmodule
